// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Types and default constants shared by the SNN layer scheduler and its LIF
// datapath.
//   snn_state_e      : scheduler FSM state (IDLE / UPDATE / CLEAR)
//   SNN_*            : default parameter values for the layer
//   idx_width()      : neuron index width, never narrower than one bit
// ---------------------------------------------------------------------------
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_CLEAR  = 2'd2
    } snn_state_e;

    localparam int SNN_WIDTH       = 8;
    localparam int SNN_NUM_NEURONS = 4;
    localparam int SNN_LEAK_SHIFT  = 3;
    localparam int SNN_THRESHOLD   = 10;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// ---------------------------------------------------------------------------
// lif_update_unit
// Combinational leaky-integrate-and-fire step for one neuron:
//   a = sat(v - (v >>> LEAK_SHIFT) + w0*d0 + w1*d1), fire = (a >= THRESHOLD)
// Ports:
//   v, w0, w1, d0, d1 : signed WIDTH operands (membrane, weights, inputs)
//   a                 : saturated signed WIDTH result
//   fire              : a reached the threshold
// ---------------------------------------------------------------------------
module lif_update_unit
    import snn_pkg::*;
#(
    parameter int WIDTH      = SNN_WIDTH,
    parameter int LEAK_SHIFT = SNN_LEAK_SHIFT,
    parameter int THRESHOLD  = SNN_THRESHOLD
) (
    input  logic signed [WIDTH-1:0] v,
    input  logic signed [WIDTH-1:0] w0,
    input  logic signed [WIDTH-1:0] w1,
    input  logic signed [WIDTH-1:0] d0,
    input  logic signed [WIDTH-1:0] d1,
    output logic signed [WIDTH-1:0] a,
    output logic                    fire
);
    // Two full products plus the leak term cannot overflow this width.
    localparam int AW = 2 * WIDTH + 2;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] THR  = WIDTH'(THRESHOLD);

    logic signed [AW-1:0] v_x, w0_x, w1_x, d0_x, d1_x, leak_x, acc_x;

    assign v_x    = {{(AW-WIDTH){v[WIDTH-1]}},  v};
    assign w0_x   = {{(AW-WIDTH){w0[WIDTH-1]}}, w0};
    assign w1_x   = {{(AW-WIDTH){w1[WIDTH-1]}}, w1};
    assign d0_x   = {{(AW-WIDTH){d0[WIDTH-1]}}, d0};
    assign d1_x   = {{(AW-WIDTH){d1[WIDTH-1]}}, d1};
    assign leak_x = v_x >>> LEAK_SHIFT;
    assign acc_x  = v_x - leak_x + (w0_x * d0_x) + (w1_x * d1_x);

    always_comb begin
        if (acc_x > SAT_MAX) begin
            a = SAT_MAX[WIDTH-1:0];
        end else if (acc_x < SAT_MIN) begin
            a = SAT_MIN[WIDTH-1:0];
        end else begin
            a = acc_x[WIDTH-1:0];
        end
    end

    assign fire = (a >= THR);

endmodule

// File: rtl/snn_layer_scheduler.sv
// ---------------------------------------------------------------------------
// snn_layer_scheduler
// Time-multiplexes NUM_NEURONS virtual LIF neurons over one update datapath.
// A tick latches the two shared inputs and walks every neuron once (one per
// cycle); clr walks every neuron zeroing its membrane.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   en                        : global enable (low = everything holds)
//   tick, clr                 : start timestep / zero all membranes
//   data0, data1              : timestep inputs shared by all neurons
//   cfg_we/addr/weight0/1     : per-neuron weight write (accepted in IDLE)
//   busy, done                : UPDATE/CLEAR active, end-of-timestep pulse
//   spike_vec, sum, cur_idx   : last spikes, last membrane result and index
//   tick_dropped, cfg_err     : one-cycle error pulses
// ---------------------------------------------------------------------------
module snn_layer_scheduler
    import snn_pkg::*;
#(
    parameter int WIDTH       = SNN_WIDTH,
    parameter int NUM_NEURONS = SNN_NUM_NEURONS,
    parameter int LEAK_SHIFT  = SNN_LEAK_SHIFT,
    parameter int THRESHOLD   = SNN_THRESHOLD,
    localparam int IDXW       = idx_width(NUM_NEURONS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    tick,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] data0,
    input  logic signed [WIDTH-1:0] data1,
    input  logic                    cfg_we,
    input  logic [IDXW-1:0]         cfg_addr,
    input  logic signed [WIDTH-1:0] cfg_weight0,
    input  logic signed [WIDTH-1:0] cfg_weight1,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_NEURONS-1:0]  spike_vec,
    output logic signed [WIDTH-1:0] sum,
    output logic [IDXW-1:0]         cur_idx,
    output logic                    tick_dropped,
    output logic                    cfg_err
);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_NEURONS - 1);

    snn_state_e              state_q, state_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic signed [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [NUM_NEURONS-1:0]  spike_acc_q, spike_acc_d;
    logic [NUM_NEURONS-1:0]  spike_vec_q, spike_vec_d;
    logic signed [WIDTH-1:0] sum_q, sum_d;
    logic [IDXW-1:0]         cur_idx_q, cur_idx_d;
    logic                    done_q, done_d;
    logic                    tick_dropped_q, tick_dropped_d;
    logic                    cfg_err_q, cfg_err_d;

    logic signed [WIDTH-1:0] v_q  [NUM_NEURONS];
    logic signed [WIDTH-1:0] w0_q [NUM_NEURONS];
    logic signed [WIDTH-1:0] w1_q [NUM_NEURONS];

    // Membrane write port (shared by UPDATE and CLEAR) and weight write port.
    logic                    v_we;
    logic signed [WIDTH-1:0] v_wdata;
    logic                    w_we;

    logic signed [WIDTH-1:0] lif_a;
    logic                    lif_fire;

    lif_update_unit #(
        .WIDTH      (WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT),
        .THRESHOLD  (THRESHOLD)
    ) u_lif (
        .v    (v_q[idx_q]),
        .w0   (w0_q[idx_q]),
        .w1   (w1_q[idx_q]),
        .d0   (data0_q),
        .d1   (data1_q),
        .a    (lif_a),
        .fire (lif_fire)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        data0_d        = data0_q;
        data1_d        = data1_q;
        spike_acc_d    = spike_acc_q;
        spike_vec_d    = spike_vec_q;
        sum_d          = sum_q;
        cur_idx_d      = cur_idx_q;
        done_d         = done_q;
        tick_dropped_d = tick_dropped_q;
        cfg_err_d      = cfg_err_q;
        v_we           = 1'b0;
        v_wdata        = '0;
        w_we           = 1'b0;

        if (en) begin
            done_d         = 1'b0;
            tick_dropped_d = 1'b0;
            cfg_err_d      = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    w_we = cfg_we;
                    if (clr) begin
                        state_d        = ST_CLEAR;
                        idx_d          = '0;
                        tick_dropped_d = tick;
                    end else if (tick) begin
                        state_d     = ST_UPDATE;
                        idx_d       = '0;
                        data0_d     = data0;
                        data1_d     = data1;
                        spike_acc_d = '0;
                    end
                end
                ST_UPDATE: begin
                    tick_dropped_d = tick;
                    cfg_err_d      = cfg_we;
                    v_we           = 1'b1;
                    v_wdata        = lif_fire ? '0 : lif_a;
                    sum_d          = lif_a;
                    cur_idx_d      = idx_q;
                    if (lif_fire) begin
                        spike_acc_d[idx_q] = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d     = ST_IDLE;
                        spike_vec_d = spike_acc_d;
                        done_d      = 1'b1;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
                ST_CLEAR: begin
                    tick_dropped_d = tick;
                    cfg_err_d      = cfg_we;
                    v_we           = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            data0_q        <= '0;
            data1_q        <= '0;
            spike_acc_q    <= '0;
            spike_vec_q    <= '0;
            sum_q          <= '0;
            cur_idx_q      <= '0;
            done_q         <= 1'b0;
            tick_dropped_q <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            data0_q        <= data0_d;
            data1_q        <= data1_d;
            spike_acc_q    <= spike_acc_d;
            spike_vec_q    <= spike_vec_d;
            sum_q          <= sum_d;
            cur_idx_q      <= cur_idx_d;
            done_q         <= done_d;
            tick_dropped_q <= tick_dropped_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    // Per-neuron storage; address decode per entry so out-of-range
    // cfg_addr values simply write nothing.
    generate
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_q[gi]  <= '0;
                    w0_q[gi] <= '0;
                    w1_q[gi] <= '0;
                end else begin
                    if (v_we && (idx_q == IDXW'(gi))) begin
                        v_q[gi] <= v_wdata;
                    end
                    if (w_we && (cfg_addr == IDXW'(gi))) begin
                        w0_q[gi] <= cfg_weight0;
                        w1_q[gi] <= cfg_weight1;
                    end
                end
            end
        end
    endgenerate

    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign spike_vec    = spike_vec_q;
    assign sum          = sum_q;
    assign cur_idx      = cur_idx_q;
    assign tick_dropped = tick_dropped_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_snn_layer_scheduler.sv
module tb_snn_layer_scheduler;
    localparam int W    = 8;
    localparam int N    = 4;
    localparam int LS   = 3;
    localparam int THR  = 10;
    localparam int IDXW = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  en = 1'b1;
    logic                  tick = 1'b0;
    logic                  clr = 1'b0;
    logic signed [W-1:0]   data0 = '0;
    logic signed [W-1:0]   data1 = '0;
    logic                  cfg_we = 1'b0;
    logic [IDXW-1:0]       cfg_addr = '0;
    logic signed [W-1:0]   cfg_weight0 = '0;
    logic signed [W-1:0]   cfg_weight1 = '0;
    logic                  busy;
    logic                  done;
    logic [N-1:0]          spike_vec;
    logic signed [W-1:0]   sum;
    logic [IDXW-1:0]       cur_idx;
    logic                  tick_dropped;
    logic                  cfg_err;

    snn_layer_scheduler #(
        .WIDTH       (W),
        .NUM_NEURONS (N),
        .LEAK_SHIFT  (LS),
        .THRESHOLD   (THR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .tick         (tick),
        .clr          (clr),
        .data0        (data0),
        .data1        (data1),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_weight0  (cfg_weight0),
        .cfg_weight1  (cfg_weight1),
        .busy         (busy),
        .done         (done),
        .spike_vec    (spike_vec),
        .sum          (sum),
        .cur_idx      (cur_idx),
        .tick_dropped (tick_dropped),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int sum;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   vm  [N];
    int   w0m [N];
    int   w1m [N];
    int   spk_m = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lif_model(int v, int w0, int w1, int d0, int d1);
        int a;
        a = v - (v >>> LS) + w0 * d0 + w1 * d1;
        if (a > 127)  a = 127;
        if (a < -128) a = -128;
        return a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            vm[i] = 0; w0m[i] = 0; w1m[i] = 0;
        end
        spk_m = 0;
    endtask

    task automatic cfg_write(input int addr, input int wa, input int wb);
        cfg_we = 1'b1; cfg_addr = IDXW'(addr);
        cfg_weight0 = W'(wa); cfg_weight1 = W'(wb);
        w0m[addr] = wa; w1m[addr] = wb;
    endtask

    // Drives one tick (plus any cfg write already staged by the caller),
    // pushes the expected per-neuron results and checks them as they appear.
    task automatic run_tick(input int d0, input int d1, input int inject_at,
                            input int freeze_at);
        int   drops;
        int   errs;
        exp_t e;
        spk_m = 0;
        for (int i = 0; i < N; i++) begin
            int a;
            a = lif_model(vm[i], w0m[i], w1m[i], d0, d1);
            sb.push_back('{idx: i, sum: a});
            if (a >= THR) begin
                spk_m |= (1 << i);
                vm[i] = 0;
            end else begin
                vm[i] = a;
            end
        end
        tick = 1'b1; data0 = W'(d0); data1 = W'(d1);
        step();
        tick = 1'b0; cfg_we = 1'b0;
        chk("busy_start", busy, 1);
        drops = 0; errs = 0;
        for (int i = 0; i < N; i++) begin
            step();
            drops += int'(tick_dropped);
            errs  += int'(cfg_err);
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("cur_idx[%0d]", i), cur_idx, e.idx);
                chk($sformatf("sum[%0d]", i), sum, e.sum);
            end
            if (i < N - 1) begin
                chk("done_early", done, 0);
                chk("busy_mid", busy, 1);
            end else begin
                chk("done_end", done, 1);
                chk("busy_end", busy, 0);
                chk("spike_vec", spike_vec, spk_m);
            end
            tick = 1'b0; cfg_we = 1'b0;
            if (i == inject_at) begin
                tick = 1'b1; cfg_we = 1'b1; cfg_addr = '0;
                cfg_weight0 = 8'sd55; cfg_weight1 = 8'sd55;
            end
            if (i == freeze_at) begin
                en = 1'b0;
                repeat (3) begin
                    step();
                    chk("frz_idx", cur_idx, i);
                    chk("frz_busy", busy, 1);
                    chk("frz_done", done, 0);
                end
                en = 1'b1;
            end
        end
        step();
        chk("done_once", done, 0);
        if (inject_at >= 0) begin
            chk("tick_dropped_cnt", drops, 1);
            chk("cfg_err_cnt", errs, 1);
        end
        $display("[TB] tick d0=%0d d1=%0d spike_vec=%b sum=%0d", d0, d1, spike_vec, sum);
    endtask

    initial begin
        model_reset();
        repeat (2) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spike", spike_vec, 0);
        chk("rst_sum", sum, 0);
        chk("rst_idx", cur_idx, 0);
        reset = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // Neuron0 weights, then two ticks: v0 -> 8, then 15 fires
        cfg_write(0, 2, 1);
        step();
        cfg_we = 1'b0;
        run_tick(3, 2, -1, -1);
        run_tick(3, 2, -1, -1);

        // Neuron1 weight written on the same edge as the tick
        cfg_write(1, -128, -128);
        run_tick(127, 127, -1, -1);
        cfg_write(1, 127, 127);
        run_tick(127, 127, -1, -1);

        // Tick + cfg write while busy: dropped, weights must stay as modelled
        run_tick(1, 1, 1, -1);
        run_tick(1, 0, -1, -1);

        // Enable low in the middle of a timestep
        run_tick(-1, 2, -1, 1);

        // Reset asserted during the cycle that writes idx=2
        tick = 1'b1; data0 = 8'sd1; data1 = 8'sd1;
        step();
        tick = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_spike", spike_vec, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_idx", cur_idx, 0);
        model_reset();
        step();
        chk("mid_rst_done2", done, 0);
        reset = 1'b0;
        step();
        chk("post_rst_done", done, 0);
        run_tick(5, 5, -1, -1);

        // Give neuron2 a spike and neuron3 a residual membrane, then clear
        cfg_write(2, 10, 0);
        step();
        cfg_write(3, 5, 0);
        step();
        cfg_we = 1'b0;
        run_tick(1, 0, -1, -1);
        clr = 1'b1; tick = 1'b1;
        step();
        clr = 1'b0; tick = 1'b0;
        chk("clr_tick_dropped", tick_dropped, 1);
        for (int i = 0; i < N; i++) begin
            chk("clr_busy", busy, 1);
            chk("clr_done", done, 0);
            step();
        end
        chk("clr_end_busy", busy, 0);
        chk("clr_done_end", done, 0);
        chk("clr_spike_vec", spike_vec, 4'b0100);
        for (int i = 0; i < N; i++) vm[i] = 0;
        run_tick(0, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/snn_layer_scheduler.md
SNN_LAYER_SCHEDULER -- requirements
Module: snn_layer_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, 8, signed width of data, weights and membrane potential.
REQ-002 SHALL have parameter NUM_NEURONS, 4, virtual neurons time-multiplexed on one LIF update datapath.
REQ-003 SHALL have parameter LEAK_SHIFT, 3, leak term is v >>> LEAK_SHIFT.
REQ-004 SHALL have parameter THRESHOLD, 10, signed spike threshold.
REQ-005 SHALL have derived constant IDXW = max(1, clog2(NUM_NEURONS)).
REQ-006 SHALL have port clk input 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset input 1, asynchronous and active-high.
REQ-008 SHALL have port en input 1, global enable; when low, the FSM and all registers hold, and tick/clr/cfg_we are ignored.
REQ-009 SHALL have port tick input 1, start-of-timestep request.
REQ-010 SHALL have port clr input 1, request to zero all membrane potentials.
REQ-011 SHALL have ports data0 and data1, input, WIDTH signed, timestep inputs shared by all neurons.
REQ-012 SHALL have ports cfg_we input 1, cfg_addr input IDXW, cfg_weight0 and cfg_weight1 input WIDTH signed; per-neuron weight write.
REQ-013 SHALL have port busy output 1, high in UPDATE or CLEAR.
REQ-014 SHALL have port done output 1, one-cycle pulse at the end of a timestep.
REQ-015 SHALL have ports spike_vec output NUM_NEURONS (bit i = neuron i spiked in the last timestep), sum output WIDTH signed (last written membrane value), and cur_idx output IDXW.
REQ-016 SHALL have ports tick_dropped output 1 and cfg_err output 1, one-cycle error pulses.

Function
REQ-017 SHALL implement FSM states IDLE, UPDATE and CLEAR.
REQ-018 In IDLE with en=1, clr SHALL take priority: go to CLEAR, idx=0; a simultaneous tick SHALL pulse tick_dropped.
REQ-019 In IDLE with en=1, tick=1 and clr=0, the FSM SHALL latch data0/data1, set idx=0, and go to UPDATE.
REQ-020 UPDATE SHALL process one neuron per cycle: a = v[idx] - (v[idx] >>> LEAK_SHIFT) + w0[idx]*data0_q + w1[idx]*data1_q, computed at 2*WIDTH+2 bits and saturated to the signed WIDTH range.
REQ-021 UPDATE: if a >= THRESHOLD, set spike bit idx and write v[idx]=0; else write v[idx]=a; in both cases set sum=a and cur_idx=idx.
REQ-022 On the edge writing idx=NUM_NEURONS-1, the FSM SHALL return to IDLE, load spike_vec from the accumulated bits, and assert done for the next cycle only.
REQ-023 Latency: with tick sampled at edge k, neuron i SHALL be written at edge k+1+i, and done SHALL be high during the cycle after edge k+NUM_NEURONS.
REQ-024 CLEAR SHALL zero v[idx] once per cycle, return to IDLE after the last index, and SHALL NOT pulse done or alter spike_vec.
REQ-025 cfg_we in IDLE SHALL write both weights at cfg_addr; the same-edge write SHALL be visible to the timestep started by that edge's tick.
REQ-026 cfg_we while busy SHALL be ignored and SHALL pulse cfg_err.
REQ-027 tick while busy SHALL be ignored and SHALL pulse tick_dropped; no queuing.
REQ-028 en low mid-UPDATE SHALL freeze idx and state; processing SHALL resume unchanged when en returns high.

Reset
REQ-029 reset SHALL asynchronously force IDLE, idx=0, and clear all membranes, weights, spike_vec, sum, cur_idx, busy, done, tick_dropped and cfg_err to 0, including when asserted mid-UPDATE (no done pulse).

Structure
REQ-030 The FSM state enum and the default WIDTH/THRESHOLD/LEAK_SHIFT constants SHALL live in shared package snn_pkg.
REQ-031 The combinational leak/MAC/saturate/threshold logic SHALL be sub-module lif_update_unit (inputs v, w0, w1, d0, d1; outputs a, fire).

Verification (WIDTH=8, NUM_NEURONS=4, LEAK_SHIFT=3, THRESHOLD=10)
REQ-032 Write neuron0 w0=2, w1=1, then tick with d0=3, d1=2 -> v0=8, done exactly 4 cycles later, spike_vec=0000.
REQ-033 Repeat the tick -> a=8-1+8=15, spike_vec[0]=1, v0=0, sum=15 while cur_idx=0.
REQ-034 Neuron1 w0=w1=-128, d0=d1=127 -> sum saturates to -128, no spike; w0=w1=127 -> sum=127, spike.
REQ-035 tick and cfg_we during UPDATE -> one tick_dropped pulse, one cfg_err pulse, weights unchanged, exactly one done.
REQ-036 Assert reset at the cycle writing idx=2 -> busy=0 immediately, no done, all v=0; then clr with tick -> CLEAR for 4 cycles, tick_dropped=1, spike_vec unchanged.
